// File: rtl/ysyx_22050368_mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - Bit positions of the one-hot MULDIV op vector. They follow the decoder's MULDIV
//     info-group order: bit0=MUL ... bit7=REMU.
//   - Encodings for the MDU FSM states.
package ysyx_22050368_mdu_pkg;

    localparam int unsigned OpMul    = 0;
    localparam int unsigned OpMulh   = 1;
    localparam int unsigned OpMulhsu = 2;
    localparam int unsigned OpMulhu  = 3;
    localparam int unsigned OpDiv    = 4;
    localparam int unsigned OpDivu   = 5;
    localparam int unsigned OpRem    = 6;
    localparam int unsigned OpRemu   = 7;

    localparam int unsigned OpWidth  = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ysyx_22050368_mdu_divider.sv
// One step of an unsigned restoring divider. The step is purely combinational.
// The caller holds the partial remainder and the quotient/dividend shift register.
// Ports:
//   rem_i     partial remainder before this step
//   quo_i     quotient shift register; its MSB is the next dividend bit shifted in
//   divisor_i divisor magnitude
//   rem_o     partial remainder after this step
//   quo_o     quotient register shifted left by one, with the new quotient bit in the LSB
module ysyx_22050368_mdu_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        // A borrow out of the MSB means the trial subtraction went negative.
        // In that case restore the shifted remainder.
        if (diff[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
        end else begin
            rem_o = diff[XLEN-1:0];
        end
        quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    end

endmodule

// File: rtl/ysyx_22050368_mdu.sv
// Iterative RV64M multiply/divide unit with a start/ready/valid handshake.
// The unit runs MUL/MULH/MULHSU/MULHU with a shift-add multiplier.
// It runs DIV/DIVU/REM/REMU with a restoring divider.
// Both work on operand magnitudes, one bit per cycle. Each op handles its sign
// before and after the calculation.
// Optional build macro MDU_FAST_MUL_EN: multiply ops use a single-cycle combinational
// product instead of the iterative multiplier.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_i, op_i   request and one-hot op {REMU,REM,DIVU,DIV,MULHU,MULHSU,MULH,MUL}
//   rs1/rs2_rdata_i operands; rd_waddr_i destination captured on accept
//   flush_i         abort any in-flight op, no result
//   ready_o/busy_o  idle indication / stall request
//   result_o, result_valid_o, rd_waddr_o, rd_we_o  one-cycle result pulse
module ysyx_22050368_mdu
    import ysyx_22050368_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [OpWidth-1:0] op_i,
    input  logic [XLEN-1:0]    rs1_rdata_i,
    input  logic [XLEN-1:0]    rs2_rdata_i,
    input  logic [4:0]         rd_waddr_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic [XLEN-1:0]    result_o,
    output logic               result_valid_o,
    output logic [4:0]         rd_waddr_o,
    output logic               rd_we_o
);

    localparam int unsigned    CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMin    = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OpWidth-1:0]  op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic                neg_q, neg_d;    // negate the final result
    logic [2*XLEN-1:0]   acc_q, acc_d;    // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]     res_q, res_d;

    // Request decode
    logic            accept;
    logic            req_mul, rs1_signed, rs2_signed, s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;

    // Iteration datapath
    logic              is_mul_q, is_quot_q, is_rem_q;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_prod;
    logic [XLEN-1:0]   div_rem, div_quo;

    always_comb begin
        accept     = start_i & (state_q == StIdle) & (|op_i) & ~flush_i;
        req_mul    = |op_i[OpMulhu:OpMul];
        rs1_signed = op_i[OpMulh] | op_i[OpMulhsu] | op_i[OpDiv] | op_i[OpRem];
        rs2_signed = op_i[OpMulh] | op_i[OpDiv] | op_i[OpRem];
        s1         = rs1_signed & rs1_rdata_i[XLEN-1];
        s2         = rs2_signed & rs2_rdata_i[XLEN-1];
        mag1       = s1 ? -rs1_rdata_i : rs1_rdata_i;
        mag2       = s2 ? -rs2_rdata_i : rs2_rdata_i;
        div_zero   = ~|rs2_rdata_i;
        div_ovf    = (op_i[OpDiv] | op_i[OpRem]) & (rs1_rdata_i == XMin) & (&rs2_rdata_i);
    end

    always_comb begin
        is_mul_q  = |op_q[OpMulhu:OpMul];
        is_quot_q = |op_q[OpDivu:OpDiv];
        is_rem_q  = |op_q[OpRemu:OpRem];
        // Shift-add: the multiplier sits in acc lo and is consumed from bit 0.
        // The sum carry shifts into the top of hi.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod  = neg_q ? -mul_next : mul_next;
    end

    ysyx_22050368_mdu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quo_i     (acc_q[XLEN-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_signed;

    always_comb begin
        fast_prod   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_signed = (s1 ^ s2) ? -fast_prod : fast_prod;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        res_d   = res_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = op_i;
                    rd_d  = rd_waddr_i;
                    cnt_d = '0;
                    // The remainder takes the dividend's sign. Every other op takes the XOR.
                    neg_d = (op_i[OpRem] | op_i[OpRemu]) ? s1 : (s1 ^ s2);
                    if (req_mul) begin
`ifdef MDU_FAST_MUL_EN
                        res_d   = op_i[OpMul] ? fast_signed[XLEN-1:0]
                                              : fast_signed[2*XLEN-1:XLEN];
                        state_d = StDone;
`else
                        acc_d   = {{XLEN{1'b0}}, mag2};
                        opnd_d  = mag1;
                        state_d = StCalc;
`endif
                    end else if (div_zero) begin
                        res_d   = (op_i[OpDiv] | op_i[OpDivu]) ? '1 : rs1_rdata_i;
                        state_d = StDone;
                    end else if (div_ovf) begin
                        res_d   = op_i[OpDiv] ? rs1_rdata_i : '0;
                        state_d = StDone;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, mag1};
                        opnd_d  = mag2;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = is_mul_q ? mul_next : {div_rem, div_quo};
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    if (is_mul_q) begin
                        res_d = op_q[OpMul] ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                    end else if (is_quot_q) begin
                        res_d = neg_q ? -div_quo : div_quo;
                    end else if (is_rem_q) begin
                        res_d = neg_q ? -div_rem : div_rem;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        ready_o        = (state_q == StIdle);
        busy_o         = (state_q == StCalc) | (state_q == StDone);
        result_valid_o = (state_q == StDone);
        rd_we_o        = result_valid_o;
        result_o       = result_valid_o ? res_q : '0;
        rd_waddr_o     = result_valid_o ? rd_q : '0;
    end

endmodule

// File: tb/tb_ysyx_22050368_mdu.sv
// Self-checking bench for the RV64M multiply/divide unit.
// The reference model uses 128-bit arithmetic and native signed divide.
// A queue of expected results, each tagged with its due cycle, is checked every cycle.
module tb_ysyx_22050368_mdu;

    localparam logic [7:0] MUL    = 8'h01;
    localparam logic [7:0] MULH   = 8'h02;
    localparam logic [7:0] MULHSU = 8'h04;
    localparam logic [7:0] MULHU  = 8'h08;
    localparam logic [7:0] DIV    = 8'h10;
    localparam logic [7:0] DIVU   = 8'h20;
    localparam logic [7:0] REM    = 8'h40;
    localparam logic [7:0] REMU   = 8'h80;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  op_i = '0;
    logic [63:0] rs1_rdata_i = '0;
    logic [63:0] rs2_rdata_i = '0;
    logic [4:0]  rd_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, busy_o, result_valid_o, rd_we_o;
    logic [63:0] result_o;
    logic [4:0]  rd_waddr_o;

    ysyx_22050368_mdu u_dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .op_i           (op_i),
        .rs1_rdata_i    (rs1_rdata_i),
        .rs2_rdata_i    (rs2_rdata_i),
        .rd_waddr_i     (rd_waddr_i),
        .flush_i        (flush_i),
        .ready_o        (ready_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .rd_waddr_o     (rd_waddr_o),
        .rd_we_o        (rd_we_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    bit          m_ready = 1'b1;
    logic [63:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    // The decoder guarantees a one-hot op.
    always @(posedge clk) begin
        if (start_i && !$onehot0(op_i)) $error("op_i not one-hot: %b", op_i);
    end

    function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] sa, sb, za, zb, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        za = {64'd0, a};
        zb = {64'd0, b};
        p  = '0;
        case (op)
            MUL:    begin p = za * zb; return p[63:0];   end
            MULH:   begin p = sa * sb; return p[127:64]; end
            MULHSU: begin p = sa * zb; return p[127:64]; end
            MULHU:  begin p = za * zb; return p[127:64]; end
            DIV:    begin
                if (b == 0) return ONES;
                if (a == MIN64 && b == ONES) return a;
                return $signed(a) / $signed(b);
            end
            DIVU:   return (b == 0) ? ONES : a / b;
            REM:    begin
                if (b == 0) return a;
                if (a == MIN64 && b == ONES) return 64'd0;
                return $signed(a) % $signed(b);
            end
            REMU:   return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int latency(input logic [7:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        if (op inside {MUL, MULH, MULHSU, MULHU}) begin
`ifdef MDU_FAST_MUL_EN
            return 1;
`else
            return 65;
`endif
        end
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == MIN64 && b == ONES) return 1;
        return 65;
    endfunction

    // Per-cycle comparison of all outputs against the model.
    initial begin
        logic        e_valid;
        logic [63:0] e_res;
        logic [4:0]  e_rd;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk_en) begin
                m_ready = (q.size() == 0);
                e_valid = 1'b0;
                e_res   = '0;
                e_rd    = '0;
                if (q.size() != 0 && q[0].due == cyc) begin
                    e_valid  = 1'b1;
                    e_res    = q[0].res;
                    e_rd     = q[0].rd;
                    last_res = result_o;
                    last_rd  = rd_waddr_o;
                    void'(q.pop_front());
                end
                tests++;
                if (ready_o !== m_ready || busy_o !== !m_ready || result_valid_o !== e_valid ||
                    rd_we_o !== e_valid || result_o !== e_res || rd_waddr_o !== e_rd) begin
                    fails++;
                    $display("FAIL cycle %0d outputs: ready=%b busy=%b valid=%b we=%b res=%h rd=%0d; want ready=%b busy=%b valid=%b res=%h rd=%0d",
                             cyc, ready_o, busy_o, result_valid_o, rd_we_o, result_o,
                             rd_waddr_o, m_ready, !m_ready, e_valid, e_res, e_rd);
                end
            end
        end
    end

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at a negedge: drive one request cycle and record it if the model accepts it.
    task automatic drive(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        exp_t e;
        start_i     = 1'b1;
        op_i        = op;
        rs1_rdata_i = a;
        rs2_rdata_i = b;
        rd_waddr_i  = rd;
        if (m_ready && op != 0 && !flush_i && !rst) begin
            e.res = model(op, a, b);
            e.rd  = rd;
            e.due = cyc + latency(op, a, b);
            q.push_back(e);
        end
    endtask

    task automatic release_start();
        start_i = 1'b0;
        op_i    = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            tests++;
            fails++;
            $display("FAIL wait_ready: timeout, got busy want ready");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL wait_done: timeout, got %0d pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        wait_ready();
        drive(op, a, b, rd);
        @(negedge clk);
        release_start();
        wait_done();
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return ONES;
            2: return MIN64;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [63:0] a, b, want;
    } dir_t;

    dir_t dirs[$];

    initial begin
        logic [7:0] rop;
        dirs.push_back('{"mul 3*-5",   MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1});
        dirs.push_back('{"mulhu -1*-1", MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE});
        dirs.push_back('{"mulh -1*-1",  MULH,  ONES, ONES, 64'd0});
        dirs.push_back('{"mulhsu -1*-1", MULHSU, ONES, ONES, ONES});
        dirs.push_back('{"div -7/2",    DIV,   -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
        dirs.push_back('{"rem -7/2",    REM,   -64'd7, 64'd2, ONES});
        dirs.push_back('{"divu 7/0",    DIVU,  64'd7, 64'd0, ONES});
        dirs.push_back('{"rem 7/0",     REM,   64'd7, 64'd0, 64'd7});
        dirs.push_back('{"div ovf",     DIV,   MIN64, ONES, MIN64});
        dirs.push_back('{"rem ovf",     REM,   MIN64, ONES, 64'd0});

        // Reset
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check64("reset ready_o", {63'd0, ready_o}, 64'd1);
        check64("reset result_o", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases: pin the model and the DUT to literals.
        foreach (dirs[i]) begin
            check64({"model ", dirs[i].name}, model(dirs[i].op, dirs[i].a, dirs[i].b),
                    dirs[i].want);
            run_op(dirs[i].op, dirs[i].a, dirs[i].b, 5'(i + 1));
            check64({"dut ", dirs[i].name}, last_res, dirs[i].want);
        end

        // A start with no op bit set is ignored.
        drive(8'h00, 64'd5, 64'd5, 5'd3);
        @(negedge clk);
        release_start();
        @(negedge clk);

        // When flush arrives in the same cycle as start, flush wins.
        flush_i = 1'b1;
        drive(MUL, 64'd5, 64'd5, 5'd3);
        @(negedge clk);
        flush_i = 1'b0;
        release_start();
        @(negedge clk);

        // Flush 10 cycles into CALC.
        drive(DIV, 64'd1000, 64'd3, 5'd4);
        @(negedge clk);
        release_start();
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        q.delete();
        @(negedge clk);
        flush_i = 1'b0;
        check64("flush ready_o", {63'd0, ready_o}, 64'd1);
        @(negedge clk);

        // Reset 30 cycles into CALC.
        drive(MULHU, ONES, 64'd12345, 5'd6);
        @(negedge clk);
        release_start();
        repeat (29) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check64("rst busy_o", {63'd0, busy_o}, 64'd0);
        check64("rst rd_waddr_o", {59'd0, rd_waddr_o}, 64'd0);
        @(negedge clk);

        // Hold start through a whole DIVU.
        // Start is ignored while busy; the next op is accepted the cycle after DONE.
        for (int i = 0; i < 68; i++) begin
            drive(DIVU, 64'd100, 64'd7, 5'd9);
            @(negedge clk);
        end
        release_start();
        check64("held divu result", last_res, 64'd14);
        check64("held divu rd", {59'd0, last_rd}, 64'd9);
        check64("held second accept pending", 64'(q.size()), 64'd1);
        wait_done();

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            rop = 8'd1 << $urandom_range(0, 7);
            run_op(rop, rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
